// File: rtl/hog_pix_feeder.sv
// hog_pix_feeder: packs a byte-wide pixel stream into 4-pixel words, buffers them and serves HOG requests.
// Optional diagnostics (underrun_cnt, ovf_stall) are enabled with `define HOG_FEED_STAT_EN.
module hog_pix_feeder #(
    parameter int PIX_W       = 8,
    parameter int DEPTH       = 16,
    parameter int FRAME_WORDS = 19200
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pix_valid,
    input  logic                      pix_sof,
    input  logic [PIX_W-1:0]          pix_data,
    output logic                      pix_ready,
    input  logic                      request,
    output logic                      ready,
    output logic [4*PIX_W-1:0]        i_data,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      frame_done,
    output logic                      sync_err
`ifdef HOG_FEED_STAT_EN
    ,
    output logic [15:0]               underrun_cnt,
    output logic                      ovf_stall
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(FRAME_WORDS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                state_r;
    logic [1:0]            lane_r;
    logic [CW-1:0]         word_cnt_r;
    logic [3*PIX_W-1:0]    pend_r;
    logic                  last_pop_r;
    logic [4*PIX_W-1:0]    mem_r [DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;

    logic                  accept_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  room_s;
    logic [LW-1:0]         level_nxt_s;
    logic [4*PIX_W-1:0]    word_s;

    assign accept_s    = pix_valid && pix_ready;
    assign push_s      = (state_r == S_RUN) && accept_s && !pix_sof && (lane_r == 2'd3);
    assign pop_s       = request && (fifo_level != LW'(0));
    assign level_nxt_s = fifo_level + LW'(push_s) - LW'(pop_s);
    // pix_ready reflects the level after this edge, so a full FIFO can never be pushed
    assign room_s      = level_nxt_s < LW'(DEPTH);
    assign word_s      = {pix_data, pend_r};

    // Frame FSM: lane packing, word counting, resync and end-of-frame handling
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= S_IDLE;
            lane_r     <= 2'd0;
            word_cnt_r <= '0;
            pend_r     <= '0;
            last_pop_r <= 1'b0;
            pix_ready  <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (accept_s && pix_sof) begin
                        pend_r[PIX_W-1:0] <= pix_data;
                        lane_r     <= 2'd1;
                        word_cnt_r <= '0;
                        state_r    <= S_RUN;
                        pix_ready  <= room_s;
                    end else begin
                        pix_ready  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (accept_s && pix_sof) begin
                        // Resync: drop the partial word, keep already buffered words
                        pend_r[PIX_W-1:0] <= pix_data;
                        lane_r     <= 2'd1;
                        word_cnt_r <= '0;
                        sync_err   <= 1'b1;
                        pix_ready  <= room_s;
                    end else if (accept_s && (lane_r == 2'd3)) begin
                        lane_r     <= 2'd0;
                        word_cnt_r <= word_cnt_r + CW'(1);
                        if (word_cnt_r == CW'(FRAME_WORDS - 1)) begin
                            state_r   <= S_DRAIN;
                            pix_ready <= 1'b0;
                        end else begin
                            pix_ready <= room_s;
                        end
                    end else if (accept_s) begin
                        case (lane_r)
                            2'd0:    pend_r[PIX_W-1:0]         <= pix_data;
                            2'd1:    pend_r[2*PIX_W-1:PIX_W]   <= pix_data;
                            2'd2:    pend_r[3*PIX_W-1:2*PIX_W] <= pix_data;
                            default: pend_r                    <= pend_r;
                        endcase
                        lane_r    <= lane_r + 2'd1;
                        pix_ready <= room_s;
                    end else begin
                        pix_ready <= room_s;
                    end
                end
                S_DRAIN: begin
                    if (last_pop_r) begin
                        frame_done <= 1'b1;
                        last_pop_r <= 1'b0;
                        state_r    <= S_IDLE;
                        pix_ready  <= 1'b1;
                    end else if (pop_s && (fifo_level == LW'(1))) begin
                        last_pop_r <= 1'b1;
                        pix_ready  <= 1'b0;
                    end else begin
                        pix_ready  <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= S_IDLE;
                    lane_r     <= 2'd0;
                    word_cnt_r <= '0;
                    last_pop_r <= 1'b0;
                    pix_ready  <= 1'b0;
                end
            endcase
        end
    end

    // Word storage
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= word_s;
        end
    end

    // FIFO pointers, naturally wrapping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
        end
    end

    // HOG-side output: one word per request edge, i_data holds otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready      <= 1'b0;
            i_data     <= '0;
            fifo_level <= '0;
        end else begin
            fifo_level <= level_nxt_s;
            if (pop_s) begin
                ready  <= 1'b1;
                i_data <= mem_r[rd_ptr_r];
            end else begin
                ready  <= 1'b0;
            end
        end
    end

`ifdef HOG_FEED_STAT_EN
    // Underrun counter: HOG asked for data while a frame is active and nothing is buffered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underrun_cnt <= 16'h0000;
        end else if (accept_s && pix_sof) begin
            underrun_cnt <= 16'h0000;
        end else if (request && (fifo_level == LW'(0)) && (state_r != S_IDLE)
                     && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'h0001;
        end
    end

    assign ovf_stall = pix_valid && (fifo_level == LW'(DEPTH)) && (state_r == S_RUN);
`endif

endmodule
